// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard sequencer: shadow-register entry and
// per-cycle operating mode.
package hazard_pkg;

    localparam int HZ_REG_AW = 5;

    // One in-flight destination: valid only for instructions that write a
    // non-zero register.
    typedef struct packed {
        logic                 valid;
        logic [HZ_REG_AW-1:0] rd;
    } sb_entry_t;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        HAZARD   = 2'd1,
        REDIRECT = 2'd2,
        FREEZE   = 2'd3
    } mode_e;

    localparam sb_entry_t SB_EMPTY = '0;

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;

    // Next count: clear, else increment unless already at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !(&cnt_q)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard sequencer for a 5-stage pipe without forwarding.
//
//   mode     | meaning
//   ---------+-----------------------------------------------------------
//   RUN      | pipe advances; ID instruction enters the EX shadow slot
//   HAZARD   | RAW on an in-flight rd: hold PC and IF/ID, bubble ID/EX
//   REDIRECT | EX-resolved taken control flow: flush IF/ID and ID/EX
//   FREEZE   | data memory busy: everything holds, shadow included
//
// The shadow (EX, MEM, WB) is the only state; the mode is decided each
// cycle from it and the inputs.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_AW    = 5,
    parameter int WB_BYPASS = 0,
    parameter int CNT_W     = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_rd_wren,
    input  logic              ex_redirect,
    input  logic              dmem_stall,
    input  logic              cnt_clr,
    output logic              pc_en,
    output logic              if_id_en,
    output logic              if_id_flush,
    output logic              id_ex_flush,
    output logic              hazard_stall,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt,
    output logic [CNT_W-1:0]  freeze_cnt
);

    sb_entry_t ex_d, ex_q;
    sb_entry_t mem_d, mem_q;
    sb_entry_t wb_d, wb_q;
    mode_e     mode;
    logic      rs1_hit;
    logic      rs2_hit;
    logic      raw;

    // Source-vs-shadow compare; with write-through regfile the WB slot is
    // already visible to ID and cannot cause a hazard.
    always_comb begin
        rs1_hit = (ex_q.valid && ex_q.rd == id_rs1) ||
                  (mem_q.valid && mem_q.rd == id_rs1) ||
                  (WB_BYPASS == 0 && wb_q.valid && wb_q.rd == id_rs1);
        rs2_hit = (ex_q.valid && ex_q.rd == id_rs2) ||
                  (mem_q.valid && mem_q.rd == id_rs2) ||
                  (WB_BYPASS == 0 && wb_q.valid && wb_q.rd == id_rs2);
        raw     = id_valid &&
                  ((id_rs1_used && id_rs1 != '0 && rs1_hit) ||
                   (id_rs2_used && id_rs2 != '0 && rs2_hit));
    end

    // Mode select, pipe controls and next shadow contents.
    always_comb begin
        mode         = RUN;
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        hazard_stall = 1'b0;
        ex_d.valid   = id_valid && id_rd_wren && (id_rd != '0);
        ex_d.rd      = id_rd;
        mem_d        = ex_q;
        wb_d         = mem_q;
        if (dmem_stall) begin
            // A pending redirect stays in EX and is re-presented afterwards.
            mode     = FREEZE;
            pc_en    = 1'b0;
            if_id_en = 1'b0;
            ex_d     = ex_q;
            mem_d    = mem_q;
            wb_d     = wb_q;
        end else if (ex_redirect) begin
            mode        = REDIRECT;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            ex_d        = SB_EMPTY;
        end else if (raw) begin
            mode         = HAZARD;
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_flush  = 1'b1;
            hazard_stall = 1'b1;
            ex_d         = SB_EMPTY;
        end
    end

    // Shadow shift register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q  <= SB_EMPTY;
            mem_q <= SB_EMPTY;
            wb_q  <= SB_EMPTY;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .inc   (mode == HAZARD),
        .cnt   (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .inc   (mode == REDIRECT),
        .cnt   (flush_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_freeze_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .inc   (mode == FREEZE),
        .cnt   (freeze_cnt)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench: dut0 has no WB bypass and 32-bit counters, dut1 has WB
// bypass and 4-bit counters. Both see the same inputs; each scenario resets
// and then checks only the instance it targets.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       id_valid, id_rs1_used, id_rs2_used, id_rd_wren;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       ex_redirect, dmem_stall, cnt_clr;

    logic        pc_en_0, if_id_en_0, if_id_flush_0, id_ex_flush_0, hazard_stall_0;
    logic [31:0] stall_cnt_0, flush_cnt_0, freeze_cnt_0;
    logic        pc_en_1, if_id_en_1, if_id_flush_1, id_ex_flush_1, hazard_stall_1;
    logic [3:0]  stall_cnt_1, flush_cnt_1, freeze_cnt_1;

    int n_chk  = 0;
    int n_fail = 0;
    int n;

    always #5 clk = ~clk;

    hazard_ctrl #(.REG_AW(5), .WB_BYPASS(0), .CNT_W(32)) dut0 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
        .id_rd_wren(id_rd_wren), .ex_redirect(ex_redirect), .dmem_stall(dmem_stall),
        .cnt_clr(cnt_clr), .pc_en(pc_en_0), .if_id_en(if_id_en_0),
        .if_id_flush(if_id_flush_0), .id_ex_flush(id_ex_flush_0),
        .hazard_stall(hazard_stall_0), .stall_cnt(stall_cnt_0),
        .flush_cnt(flush_cnt_0), .freeze_cnt(freeze_cnt_0)
    );

    hazard_ctrl #(.REG_AW(5), .WB_BYPASS(1), .CNT_W(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
        .id_rd_wren(id_rd_wren), .ex_redirect(ex_redirect), .dmem_stall(dmem_stall),
        .cnt_clr(cnt_clr), .pc_en(pc_en_1), .if_id_en(if_id_en_1),
        .if_id_flush(if_id_flush_1), .id_ex_flush(id_ex_flush_1),
        .hazard_stall(hazard_stall_1), .stall_cnt(stall_cnt_1),
        .flush_cnt(flush_cnt_1), .freeze_cnt(freeze_cnt_1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic idle();
        id_valid    = 1'b0;
        id_rs1      = '0;
        id_rs2      = '0;
        id_rs1_used = 1'b0;
        id_rs2_used = 1'b0;
        id_rd       = '0;
        id_rd_wren  = 1'b0;
        ex_redirect = 1'b0;
        dmem_stall  = 1'b0;
        cnt_clr     = 1'b0;
    endtask

    task automatic instr(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        id_valid    = 1'b1;
        id_rd       = rd;
        id_rd_wren  = 1'b1;
        id_rs1      = rs1;
        id_rs1_used = 1'b1;
        id_rs2      = rs2;
        id_rs2_used = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    // Counts hazard cycles for the consumer already in ID; bounded at 8.
    task automatic count_stalls(input bit sel, output int cnt);
        logic hz;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            #1;
            hz = sel ? hazard_stall_1 : hazard_stall_0;
            if (hz) begin
                chk("stall_pc_en", sel ? pc_en_1 : pc_en_0, 0);
                chk("stall_bubble", sel ? id_ex_flush_1 : id_ex_flush_0, 1);
                cnt++;
                tick();
            end else begin
                break;
            end
        end
        chk("issue_pc_en", sel ? pc_en_1 : pc_en_0, 1);
    endtask

    // Producer writing prd, gap independent instructions, then add x6,x5,x1.
    task automatic dep_seq(input bit sel, input logic [4:0] prd, input int gap, output int cnt);
        do_reset();
        instr(prd, 5'd0, 5'd0);
        tick();
        for (int g = 0; g < gap; g++) begin
            instr(5'd7, 5'd0, 5'd0);
            tick();
        end
        instr(5'd6, 5'd5, 5'd1);
        count_stalls(sel, cnt);
        tick();
        idle();
    endtask

    initial begin
        idle();
        do_reset();
        #1;
        chk("rst_pc_en", pc_en_0, 1);
        chk("rst_if_id_en", if_id_en_0, 1);
        chk("rst_if_id_flush", if_id_flush_0, 0);
        chk("rst_id_ex_flush", id_ex_flush_0, 0);
        chk("rst_hazard", hazard_stall_0, 0);
        chk("rst_stall_cnt", stall_cnt_0, 0);
        chk("rst_flush_cnt", flush_cnt_0, 0);
        chk("rst_freeze_cnt", freeze_cnt_0, 0);

        // Back-to-back dependency
        dep_seq(0, 5'd5, 0, n);
        chk("b2b_nobyp_stalls", n, 3);
        chk("b2b_nobyp_cnt", stall_cnt_0, 3);
        dep_seq(1, 5'd5, 0, n);
        chk("b2b_byp_stalls", n, 2);
        chk("b2b_byp_cnt", {28'd0, stall_cnt_1}, 2);
        dep_seq(0, 5'd0, 0, n);
        chk("x0_prod_stalls", n, 0);
        chk("x0_prod_cnt", stall_cnt_0, 0);

        // Distance 2 and 3
        dep_seq(0, 5'd5, 1, n);
        chk("dist2_nobyp_stalls", n, 2);
        dep_seq(0, 5'd5, 2, n);
        chk("dist3_nobyp_stalls", n, 1);
        dep_seq(1, 5'd5, 2, n);
        chk("dist3_byp_stalls", n, 0);

        // Redirect overrides a RAW hazard; redirecting producer stays tracked
        do_reset();
        instr(5'd5, 5'd0, 5'd0);
        tick();
        instr(5'd6, 5'd5, 5'd1);
        ex_redirect = 1'b1;
        #1;
        chk("redir_if_id_flush", if_id_flush_0, 1);
        chk("redir_id_ex_flush", id_ex_flush_0, 1);
        chk("redir_pc_en", pc_en_0, 1);
        chk("redir_if_id_en", if_id_en_0, 1);
        chk("redir_hazard", hazard_stall_0, 0);
        tick();
        ex_redirect = 1'b0;
        chk("redir_flush_cnt", flush_cnt_0, 1);
        chk("redir_stall_cnt", stall_cnt_0, 0);
        count_stalls(0, n);
        chk("redir_tracked_stalls", n, 2);
        tick();
        idle();

        // Freeze in the middle of a hazard
        do_reset();
        instr(5'd5, 5'd0, 5'd0);
        tick();
        instr(5'd6, 5'd5, 5'd1);
        #1;
        chk("frz_pre_hazard", hazard_stall_0, 1);
        tick();
        dmem_stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("frz_pc_en", pc_en_0, 0);
            chk("frz_if_id_en", if_id_en_0, 0);
            chk("frz_hazard", hazard_stall_0, 0);
            chk("frz_id_ex_flush", id_ex_flush_0, 0);
            tick();
        end
        dmem_stall = 1'b0;
        chk("frz_freeze_cnt", freeze_cnt_0, 4);
        count_stalls(0, n);
        chk("frz_resume_stalls", n, 2);
        tick();
        chk("frz_stall_cnt", stall_cnt_0, 3);
        idle();

        // Reset asserted mid-stall
        do_reset();
        instr(5'd5, 5'd0, 5'd0);
        tick();
        instr(5'd6, 5'd5, 5'd1);
        #1;
        chk("mrst_pre_hazard", hazard_stall_0, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_hazard", hazard_stall_0, 0);
        chk("mrst_pc_en", pc_en_0, 1);
        #2;
        rst_n = 1'b1;
        #1;
        chk("mrst_release_pc_en", pc_en_0, 1);
        tick();
        chk("mrst_stall_cnt", stall_cnt_0, 0);
        idle();

        // Saturation and clear-over-increment on the 4-bit counters
        do_reset();
        dmem_stall = 1'b1;
        repeat (18) tick();
        chk("sat_freeze_cnt4", {28'd0, freeze_cnt_1}, 15);
        chk("sat_freeze_cnt32", freeze_cnt_0, 18);
        cnt_clr = 1'b1;
        tick();
        chk("clr_freeze_cnt4", {28'd0, freeze_cnt_1}, 0);
        chk("clr_freeze_cnt32", freeze_cnt_0, 0);
        cnt_clr = 1'b0;
        tick();
        chk("post_clr_freeze_cnt4", {28'd0, freeze_cnt_1}, 1);
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
